bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//  Parallel-to-serial front end for the serial FSM detector stage. Takes W-bit words on a
//  valid/ready handshake and emits them one bit per clock as a serial stream with a
//  bit-valid qualifier. Its x_out/x_valid pair drives the detector's serial input X.
//  A one-word holding buffer allows back-to-back frames with no idle bit between them.
// PARAMETERS
//  W          8  word width, in bits (>=2)
//  MSB_FIRST  1  1: bit W-1 is sent first; 0: bit 0 is sent first
//  IDLE_LEVEL 0  x_out level when no frame is being shifted
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  reset, asynchronous, active-low
//  din        in   W  parallel word
//  din_valid  in   1  din is valid
//  din_ready  out  1  block can accept a word this cycle
//  en         in   1  shift enable; 0 freezes the bit position
//  x_out      out  1  serial bit (the detector's X)
//  x_valid    out  1  x_out carries a frame bit this cycle
//  frame_done out  1  one-cycle pulse, coincident with the last bit of a frame
//  busy       out  1  a frame is in the shifter, or a word is held in the buffer
// BEHAVIOUR
//  Reset (async assert, synchronous release):
//   - state=IDLE; shreg=0; bit_cnt=0; hold_full=0.
//   - Outputs: x_out=IDLE_LEVEL, x_valid=0, frame_done=0, busy=0, din_ready=1.
//  Handshake:
//   - Accept = din_valid & din_ready, sampled on the clock edge.
//   - din_ready = ~hold_full. It is a register-only function; there is no comb path from din_valid.
//   - din is captured only on accept. Changes on din while valid and not ready are ignored.
//  FSM (2 states):
//   - IDLE:
//     - Accept loads din into shreg with bit_cnt=0, and state goes to SHIFT.
//     - The first bit appears on x_out in the cycle after accept (latency 1).
//   - SHIFT:
//     - x_out = current bit (shreg[W-1] if MSB_FIRST, else shreg[0]).
//     - x_valid = en.
//     - When en=1, the shifter advances one bit per clock and bit_cnt increments.
//     - When en=0, shreg, bit_cnt and x_out hold, and x_valid=0.
//   - Last bit (bit_cnt==W-1 and en=1):
//     - frame_done=1 in that same cycle.
//     - Next state:
//       - hold_full=1: load the held word into shreg, clear hold_full, stay in SHIFT (no gap).
//       - hold_full=0 and accept this cycle: load din directly into shreg, stay in SHIFT (bypass, no gap).
//       - Otherwise: go to IDLE; x_out returns to IDLE_LEVEL the next cycle.
//   - An accept in SHIFT that is not a last-bit bypass writes the word into the holding
//     register and sets hold_full.
//  Other rules:
//   - Accept is allowed regardless of en.
//   - Outside SHIFT: x_out=IDLE_LEVEL and x_valid=0. x_out is never X/Z after reset.
//   - bit_cnt has width $clog2(W). It wraps to 0 on every frame load and never exceeds W-1.
//   - busy = (state==SHIFT) | hold_full.
//   - Reset asserted mid-frame aborts immediately; the partial frame and the held word are discarded.
//   - frame_done never asserts while en=0. At most one accept is possible per cycle.
// TESTING (W=8, MSB_FIRST=1, IDLE_LEVEL=0 unless stated)
//  1. Single frame: accept din=8'hB2, en=1.
//     -> x_out = 1,0,1,1,0,0,1,0 with x_valid=1 on cycles +1..+8.
//     -> frame_done only on +8; IDLE on +9 with x_out=0.
//  2. Back-to-back frames: accept 8'hFF, then 8'h00 on the next cycle.
//     -> din_ready=0 from cycle +2 until the hold is freed at the first frame's last bit
//        (it rises again the cycle after frame 1's last bit).
//     -> 16 contiguous x_valid bits: eight 1s then eight 0s, with two frame_done pulses.
//  3. Stall: 8'hA5, en=0 for 3 cycles after bit 2.
//     -> x_out holds bit 2 and x_valid=0 during the stall.
//     -> Stream resumes; total latency to frame_done = 8+3 cycles.
//  4. Bypass: with hold empty, accept 8'h0F on the last-bit cycle of the preceding frame.
//     -> Next bit is 0 (MSB of 8'h0F) with no gap; din_ready stays 1.
//  5. Reset mid-frame: rst_n=0 at bit 4 of 8'h3C, held word 8'hC3 pending.
//     -> All outputs are at reset values immediately.
//     -> After release, IDLE, din_ready=1, no residue emitted.
//  6. Ordering and idle level: MSB_FIRST=0, IDLE_LEVEL=1, din=8'h01.
//     -> x_out = 1,0,0,0,0,0,0,0 on cycles +1..+8, then returns to 1 when idle.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: W-bit words in on valid/ready, one bit per clock out with a bit-valid qualifier.
// Latency: first bit appears one cycle after accept; back-to-back frames run with no idle bit between them.
// Backpressure: din_ready = ~hold_full (registered only); en=0 freezes the bit position without dropping data.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   din, din_valid        parallel word and its valid
//   din_ready             a word can be accepted this cycle (holding buffer empty)
//   en                    shift enable; 0 holds the current bit and drops x_valid
//   x_out, x_valid        serial bit and its qualifier
//   frame_done            one-cycle pulse on the last bit of a frame
//   busy                  a frame is shifting or a word is held
module bit_serializer #(
    parameter int W          = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         en,
    output logic         x_out,
    output logic         x_valid,
    output logic         frame_done,
    output logic         busy
);

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state_q,     state_d;
    logic [W-1:0]   shreg_q,     shreg_d;
    logic [CW-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [W-1:0]   hold_q,      hold_d;
    logic           hold_full_q, hold_full_d;

    logic accept;
    logic in_shift;
    logic last_bit;
    logic cur_bit;

    always_comb begin
        accept   = din_valid & ~hold_full_q;
        in_shift = (state_q == SHIFT);
        last_bit = in_shift & en & (bit_cnt_q == LAST);
        cur_bit  = MSB_FIRST ? shreg_q[W-1] : shreg_q[0];

        din_ready  = ~hold_full_q;
        x_out      = in_shift ? cur_bit : IDLE_LEVEL;
        x_valid    = in_shift & en;
        frame_done = last_bit;
        busy       = in_shift | hold_full_q;
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d   = din;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (bit_cnt_q == LAST) begin
                        bit_cnt_d = '0;
                        if (hold_full_q) begin
                            shreg_d     = hold_q;
                            hold_full_d = 1'b0;
                        end else if (accept) begin
                            // Bypass: the new word goes straight into the shifter.
                            shreg_d = din;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d   = MSB_FIRST ? {shreg_q[W-2:0], 1'b0}
                                              : {1'b0, shreg_q[W-1:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                // Any accept other than the last-bit bypass parks the word.
                if (accept && !last_bit) begin
                    hold_d      = din;
                    hold_full_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: two instances (MSB-first/idle-0 and LSB-first/idle-1) against a word-queue model.
// Latency: model predicts outputs combinationally for the current cycle and advances at each clock edge.
// Backpressure: model readiness is "fewer than two words outstanding".
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din        [2];
    logic       din_valid  [2];
    logic       din_ready  [2];
    logic       en         [2];
    logic       x_out      [2];
    logic       x_valid    [2];
    logic       frame_done [2];
    logic       busy       [2];

    int checks = 0;
    int errors = 0;

    // Model: words accepted but not yet fully sent (index 0 is on the wire), and bit position.
    logic [7:0] mword [2][2];
    int         mcnt  [2];
    int         mpos  [2];

    // Monitor history of the emitted stream.
    logic [15:0] cap  [2];
    int          vcnt [2];
    int          dcnt [2];

    always #5 clk = ~clk;

    bit_serializer #(.W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .din_valid(din_valid[0]),
        .din_ready(din_ready[0]), .en(en[0]), .x_out(x_out[0]), .x_valid(x_valid[0]),
        .frame_done(frame_done[0]), .busy(busy[0])
    );

    bit_serializer #(.W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .din_valid(din_valid[1]),
        .din_ready(din_ready[1]), .en(en[1]), .x_out(x_out[1]), .x_valid(x_valid[1]),
        .frame_done(frame_done[1]), .busy(busy[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic sh, ebit, ex, ev, ed, eb, er, acc;
            if (!rst_n) begin
                mcnt[d] = 0;
                mpos[d] = 0;
                ex = (d == 1); ev = 1'b0; ed = 1'b0; eb = 1'b0; er = 1'b1;
            end else begin
                sh   = (mcnt[d] > 0);
                ebit = (d == 0) ? mword[d][0][7 - mpos[d]] : mword[d][0][mpos[d]];
                ex   = sh ? ebit : (d == 1);
                ev   = sh & en[d];
                ed   = sh & en[d] & (mpos[d] == 7);
                eb   = sh;
                er   = (mcnt[d] < 2);
            end
            chk($sformatf("x_out[%0d]", d),      int'(x_out[d]),      int'(ex));
            chk($sformatf("x_valid[%0d]", d),    int'(x_valid[d]),    int'(ev));
            chk($sformatf("frame_done[%0d]", d), int'(frame_done[d]), int'(ed));
            chk($sformatf("busy[%0d]", d),       int'(busy[d]),       int'(eb));
            chk($sformatf("din_ready[%0d]", d),  int'(din_ready[d]),  int'(er));

            if (x_valid[d] === 1'b1) begin
                cap[d]  = {cap[d][14:0], x_out[d]};
                vcnt[d] = vcnt[d] + 1;
            end
            if (frame_done[d] === 1'b1) dcnt[d] = dcnt[d] + 1;

            if (rst_n) begin
                acc = din_valid[d] & er;
                if (sh && en[d]) begin
                    if (mpos[d] == 7) begin
                        mword[d][0] = mword[d][1];
                        mcnt[d]     = mcnt[d] - 1;
                        mpos[d]     = 0;
                    end else begin
                        mpos[d] = mpos[d] + 1;
                    end
                end
                if (acc) begin
                    mword[d][mcnt[d]] = din[d];
                    mcnt[d]           = mcnt[d] + 1;
                end
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int v0, d0;
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0; mpos[d] = 0; cap[d] = '0; vcnt[d] = 0; dcnt[d] = 0;
            mword[d][0] = '0; mword[d][1] = '0;
            din[d] = '0; din_valid[d] = 1'b0; en[d] = 1'b1;
        end
        rst_n = 1'b0;
        tick(2);
        chk("rst_ready_a", int'(din_ready[0]), 1);
        chk("rst_busy_a",  int'(busy[0]), 0);
        chk("rst_xout_a",  int'(x_out[0]), 0);
        chk("rst_xout_b",  int'(x_out[1]), 1);
        rst_n = 1'b1;
        tick(1);

        // Single frame 0xB2.
        d0 = dcnt[0];
        din[0] = 8'hB2; din_valid[0] = 1'b1;
        tick(1);
        din_valid[0] = 1'b0;
        tick(8);
        chk("single_bits",  int'(cap[0][7:0]), 'hB2);
        chk("single_done",  dcnt[0] - d0, 1);
        chk("single_idle",  int'(busy[0]), 0);
        chk("single_xidle", int'(x_out[0]), 0);

        // Back-to-back 0xFF then 0x00.
        v0 = vcnt[0]; d0 = dcnt[0];
        din[0] = 8'hFF; din_valid[0] = 1'b1;
        tick(1);
        din[0] = 8'h00;
        tick(1);
        din_valid[0] = 1'b0;
        chk("b2b_ready_c2", int'(din_ready[0]), 0);
        tick(6);
        chk("b2b_ready_c8", int'(din_ready[0]), 0);
        tick(1);
        chk("b2b_ready_c9", int'(din_ready[0]), 1);
        tick(8);
        chk("b2b_bits",  int'(cap[0]), 'hFF00);
        chk("b2b_valid", vcnt[0] - v0, 16);
        chk("b2b_done",  dcnt[0] - d0, 2);

        // Stall of three cycles while bit 2 of 0xA5 is on the wire.
        d0 = dcnt[0];
        din[0] = 8'hA5; din_valid[0] = 1'b1;
        tick(1);
        din_valid[0] = 1'b0;
        tick(2);
        en[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_xout",  int'(x_out[0]), 1);
            chk("stall_valid", int'(x_valid[0]), 0);
            tick(1);
        end
        en[0] = 1'b1;
        tick(5);
        #1;
        chk("stall_done_c11", int'(frame_done[0]), 1);
        chk("stall_done_cnt", dcnt[0] - d0, 0);
        tick(1);
        chk("stall_bits", int'(cap[0][7:0]), 'hA5);

        // Bypass: 0x0F accepted on the last bit of 0xF0.
        din[0] = 8'hF0; din_valid[0] = 1'b1;
        tick(1);
        din_valid[0] = 1'b0;
        tick(7);
        din[0] = 8'h0F; din_valid[0] = 1'b1;
        #1;
        chk("byp_ready_last", int'(din_ready[0]), 1);
        chk("byp_done_last",  int'(frame_done[0]), 1);
        tick(1);
        din_valid[0] = 1'b0;
        #1;
        chk("byp_first_bit", int'(x_out[0]), 0);
        chk("byp_no_gap",    int'(x_valid[0]), 1);
        chk("byp_ready",     int'(din_ready[0]), 1);
        tick(8);
        chk("byp_bits", int'(cap[0]), 'hF00F);

        // Reset mid-frame with a word held.
        din[0] = 8'h3C; din_valid[0] = 1'b1;
        tick(1);
        din[0] = 8'hC3;
        tick(1);
        din_valid[0] = 1'b0;
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_xout",  int'(x_out[0]), 0);
        chk("mrst_valid", int'(x_valid[0]), 0);
        chk("mrst_busy",  int'(busy[0]), 0);
        chk("mrst_ready", int'(din_ready[0]), 1);
        tick(1);
        rst_n = 1'b1;
        v0 = vcnt[0];
        tick(12);
        chk("mrst_residue", vcnt[0] - v0, 0);
        chk("mrst_idle",    int'(busy[0]), 0);

        // LSB-first, idle-high instance with 0x01.
        din[1] = 8'h01; din_valid[1] = 1'b1;
        tick(1);
        din_valid[1] = 1'b0;
        tick(8);
        chk("lsb_bits",  int'(cap[1][7:0]), 'h80);
        chk("lsb_idle1", int'(x_out[1]), 1);

        // Randomized traffic on both instances, with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int d = 0; d < 2; d++) begin
                din[d]       = 8'($urandom);
                din_valid[d] = ($urandom_range(0, 99) < 55);
                en[d]        = ($urandom_range(0, 99) < 80);
            end
            tick(1);
        end
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            din_valid[d] = 1'b0;
            en[d]        = 1'b1;
        end
        tick(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
